// File: rtl/cdb_broadcaster.sv
// Common data bus producer: per-source result FIFOs, round-robin arbitration, one registered broadcast per cycle.
// Optional same-cycle bypass for empty FIFOs is enabled by defining CDB_BYPASS_EN.
module cdb_broadcaster #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_W     = 32,
  parameter int LABEL_W    = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*LABEL_W-1:0] src_label,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       BCEN,
  output logic [LABEL_W-1:0]         BClabel,
  output logic [DATA_W-1:0]          BCdata
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0]   count_q  [NUM_SRC];
  logic [CNT_W-1:0]   count_d  [NUM_SRC];
  logic [PTR_W-1:0]   rd_ptr_q [NUM_SRC];
  logic [PTR_W-1:0]   rd_ptr_d [NUM_SRC];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_SRC];
  logic [PTR_W-1:0]   wr_ptr_d [NUM_SRC];
  logic [LABEL_W-1:0] mem_label_q [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_data_q  [NUM_SRC][FIFO_DEPTH];

  logic [SRC_W-1:0]   last_grant_q, last_grant_d;
  logic               bcen_q, bcen_d;
  logic [LABEL_W-1:0] bc_label_q, bc_label_d;
  logic [DATA_W-1:0]  bc_data_q, bc_data_d;

  logic [NUM_SRC-1:0] accept, enq_req, eligible, enq, pop;
  logic               grant_valid, found_hi;
  logic [SRC_W-1:0]   winner, winner_hi, winner_lo;
  logic [LABEL_W-1:0] win_label;
  logic [DATA_W-1:0]  win_data;

  // Handshake: a transfer happens at a rising edge when src_valid[i] && src_ready[i];
  // ready comes only from the registered count, and a flush cycle drops the transfer.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (count_q[i] < CNT_W'(FIFO_DEPTH));
      accept[i]    = src_valid[i] && src_ready[i] && !flush;
      enq_req[i]   = accept[i] && (src_label[i*LABEL_W +: LABEL_W] != '0);
`ifdef CDB_BYPASS_EN
      eligible[i]  = (count_q[i] != '0) || enq_req[i];
`else
      eligible[i]  = (count_q[i] != '0);
`endif
    end
  end

  // Round robin: prefer the lowest eligible index above last_grant, else wrap to the lowest overall.
  always_comb begin
    grant_valid = |eligible;
    found_hi    = 1'b0;
    winner_hi   = last_grant_q;
    winner_lo   = last_grant_q;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (SRC_W'(i) > last_grant_q) begin
          winner_hi = SRC_W'(i);
          found_hi  = 1'b1;
        end else begin
          winner_lo = SRC_W'(i);
        end
      end
    end
    winner = found_hi ? winner_hi : winner_lo;
  end

  always_comb begin
    win_label = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = grant_valid && !flush && (winner == SRC_W'(i)) && (count_q[i] != '0);
      enq[i] = enq_req[i];
      if (winner == SRC_W'(i)) begin
        win_label = mem_label_q[i][rd_ptr_q[i]];
        win_data  = mem_data_q[i][rd_ptr_q[i]];
`ifdef CDB_BYPASS_EN
        if (count_q[i] == '0) begin
          win_label = src_label[i*LABEL_W +: LABEL_W];
          win_data  = src_data[i*DATA_W +: DATA_W];
          enq[i]    = enq_req[i] && !grant_valid;
        end
`endif
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      count_d[i]  = count_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      if (flush) begin
        count_d[i]  = '0;
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
      end else begin
        if (enq[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
        if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        case ({enq[i], pop[i]})
          2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
          2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
          default: count_d[i] = count_q[i];
        endcase
      end
    end
  end

  // Label and data hold their last broadcast value while the bus is idle.
  always_comb begin
    bcen_d       = grant_valid && !flush;
    bc_label_d   = bc_label_q;
    bc_data_d    = bc_data_q;
    last_grant_d = last_grant_q;
    if (bcen_d) begin
      bc_label_d   = win_label;
      bc_data_d    = win_data;
      last_grant_d = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count_q[i]  <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
      last_grant_q <= SRC_W'(NUM_SRC - 1);
      bcen_q       <= 1'b0;
      bc_label_q   <= '0;
      bc_data_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count_q[i]  <= count_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
      end
      last_grant_q <= last_grant_d;
      bcen_q       <= bcen_d;
      bc_label_q   <= bc_label_d;
      bc_data_q    <= bc_data_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (enq[i]) begin
        mem_label_q[i][wr_ptr_q[i]] <= src_label[i*LABEL_W +: LABEL_W];
        mem_data_q[i][wr_ptr_q[i]]  <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign BCEN    = bcen_q;
  assign BClabel = bc_label_q;
  assign BCdata  = bc_data_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed self-checking bench for cdb_broadcaster; expectations adapt to CDB_BYPASS_EN latency.
module tb_cdb_broadcaster;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 32;
  localparam int LABEL_W = 5;
`ifdef CDB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic                       clk;
  logic                       rst_n;
  logic                       flush;
  logic [NUM_SRC-1:0]         src_valid;
  logic [NUM_SRC*LABEL_W-1:0] src_label;
  logic [NUM_SRC*DATA_W-1:0]  src_data;
  logic [NUM_SRC-1:0]         src_ready;
  logic                       BCEN;
  logic [LABEL_W-1:0]         BClabel;
  logic [DATA_W-1:0]          BCdata;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit mon_en       = 1'b0;

  logic [LABEL_W-1:0] obs_label_q[$];
  logic [DATA_W-1:0]  obs_data_q[$];
  int                 obs_cyc_q[$];

  cdb_broadcaster #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .LABEL_W(LABEL_W), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .src_valid(src_valid), .src_label(src_label), .src_data(src_data),
    .src_ready(src_ready), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata)
  );

  // Clock / cycle counter / broadcast monitor
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && BCEN === 1'b1) begin
      obs_label_q.push_back(BClabel);
      obs_data_q.push_back(BCdata);
      obs_cyc_q.push_back(cyc);
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [LABEL_W-1:0] l,
                         input logic [DATA_W-1:0] d);
    src_valid[i]                   = v;
    src_label[i*LABEL_W +: LABEL_W] = l;
    src_data[i*DATA_W +: DATA_W]    = d;
  endtask

  task automatic clear_obs();
    obs_label_q.delete();
    obs_data_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b1, LABEL_W'(i + 1), DATA_W'(1000 + i));
    repeat (2) step();
    rst_n     = 1'b1;
    src_valid = '0;
    @(negedge clk);
    tests_run++;
    if (BCEN !== 1'b0) begin
      tests_failed++; $display("FAIL reset_bcen: got %b expected 0", BCEN);
    end
    tests_run++;
    if (BClabel !== '0) begin
      tests_failed++; $display("FAIL reset_label: got %0d expected 0", BClabel);
    end
    tests_run++;
    if (BCdata !== '0) begin
      tests_failed++; $display("FAIL reset_data: got %0d expected 0", BCdata);
    end
    tests_run++;
    if (src_ready !== 4'b1111) begin
      tests_failed++; $display("FAIL reset_ready: got %b expected 1111", src_ready);
    end
    mon_en = 1'b1;
    clear_obs();
    repeat (4) step();
    @(negedge clk);
    tests_run++;
    if (obs_label_q.size() != 0) begin
      tests_failed++; $display("FAIL reset_no_bcast: got %0d broadcasts expected 0", obs_label_q.size());
    end
  endtask

  task automatic test_single();
    logic [2:0] pat, exp_pat;
    exp_pat = (LAT == 1) ? 3'b001 : 3'b010;
    clear_obs();
    set_src(2, 1'b1, 5'd3, 32'd32);
    step();
    src_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pat[k] = BCEN;
    end
    tests_run++;
    if (pat !== exp_pat) begin
      tests_failed++; $display("FAIL single_latency: got %b expected %b", pat, exp_pat);
    end
    tests_run++;
    if (obs_label_q.size() != 1) begin
      tests_failed++; $display("FAIL single_count: got %0d expected 1", obs_label_q.size());
    end else begin
      tests_run++;
      if (obs_label_q[0] !== 5'd3 || obs_data_q[0] !== 32'd32) begin
        tests_failed++;
        $display("FAIL single_value: got label %0d data %0d expected label 3 data 32", obs_label_q[0], obs_data_q[0]);
      end
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (BCEN !== 1'b0 || BClabel !== 5'd3 || BCdata !== 32'd32) begin
      tests_failed++;
      $display("FAIL single_hold: got en %b label %0d data %0d expected en 0 label 3 data 32", BCEN, BClabel, BCdata);
    end
  endtask

  task automatic test_round_robin();
    logic [LABEL_W-1:0] exp_q[$];
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      clear_obs();
      exp_q.delete();
      for (int i = 0; i < NUM_SRC; i++) begin
        set_src(i, 1'b1, LABEL_W'(r * 4 + i + 1), DATA_W'(100 * (r * 4 + i + 1)));
        exp_q.push_back(LABEL_W'(r * 4 + i + 1));
      end
      step();
      src_valid = '0;
      repeat (6) step();
      @(negedge clk);
      tests_run++;
      if (obs_label_q.size() != exp_q.size()) begin
        tests_failed++; $display("FAIL rr%0d_count: got %0d expected %0d", r, obs_label_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < obs_label_q.size(); k++) begin
        tests_run++;
        if (obs_label_q[k] !== exp_q[k] || obs_data_q[k] !== DATA_W'(100 * exp_q[k])) begin
          tests_failed++;
          $display("FAIL rr%0d_order[%0d]: got label %0d data %0d expected label %0d data %0d",
                   r, k, obs_label_q[k], obs_data_q[k], exp_q[k], 100 * exp_q[k]);
        end
        tests_run++;
        if (obs_cyc_q[k] != obs_cyc_q[0] + k) begin
          tests_failed++;
          $display("FAIL rr%0d_b2b[%0d]: got cycle %0d expected %0d", r, k, obs_cyc_q[k], obs_cyc_q[0] + k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [LABEL_W-1:0] exp_q[$];
    int  accepted;
    int  acc_cyc[3];
    bit  saw_low;
    bit  hs;
    exp_q = '{5'd10, 5'd11, 5'd12, 5'd1, 5'd2, 5'd3};
    accepted = 0;
    saw_low  = 1'b0;
    acc_cyc  = '{0, 0, 0};
    clear_obs();
    for (int i = 1; i < NUM_SRC; i++) set_src(i, 1'b1, LABEL_W'(9 + i), DATA_W'(50 * (9 + i)));
    step();
    src_valid = '0;
    set_src(0, 1'b1, 5'd1, 32'd50);
    for (int c = 0; c < 20 && accepted < 3; c++) begin
      if (accepted == 2 && src_ready[0] === 1'b0) saw_low = 1'b1;
      hs = src_valid[0] && src_ready[0];
      step();
      if (hs) begin
        acc_cyc[accepted] = cyc;
        accepted++;
        if (accepted < 3) set_src(0, 1'b1, LABEL_W'(accepted + 1), DATA_W'(50 * (accepted + 1)));
        else set_src(0, 1'b0, 5'd0, 32'd0);
      end
    end
    src_valid = '0;
    repeat (6) step();
    @(negedge clk);
    tests_run++;
    if (accepted != 3) begin
      tests_failed++; $display("FAIL bp_accepts: got %0d expected 3", accepted);
    end
    tests_run++;
    if (saw_low !== 1'b1) begin
      tests_failed++; $display("FAIL bp_ready_low: got %b expected 1", saw_low);
    end
    tests_run++;
    if (obs_label_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL bp_count: got %0d expected %0d", obs_label_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_label_q.size(); k++) begin
      tests_run++;
      if (obs_label_q[k] !== exp_q[k] || obs_data_q[k] !== DATA_W'(50 * exp_q[k])) begin
        tests_failed++;
        $display("FAIL bp_order[%0d]: got label %0d data %0d expected label %0d data %0d",
                 k, obs_label_q[k], obs_data_q[k], exp_q[k], 50 * exp_q[k]);
      end
      tests_run++;
      if (obs_cyc_q[k] != obs_cyc_q[0] + k) begin
        tests_failed++;
        $display("FAIL bp_b2b[%0d]: got cycle %0d expected %0d", k, obs_cyc_q[k], obs_cyc_q[0] + k);
      end
    end
    if (obs_cyc_q.size() > 3) begin
      tests_run++;
      if (acc_cyc[2] <= obs_cyc_q[3]) begin
        tests_failed++;
        $display("FAIL bp_third_after_pop: got accept cycle %0d expected after %0d", acc_cyc[2], obs_cyc_q[3]);
      end
    end
  endtask

  task automatic test_label_zero();
    clear_obs();
    set_src(1, 1'b1, 5'd0, 32'd99);
    tests_run++;
    if (src_ready[1] !== 1'b1) begin
      tests_failed++; $display("FAIL l0_ready_before: got %b expected 1", src_ready[1]);
    end
    step();
    src_valid = '0;
    @(negedge clk);
    tests_run++;
    if (src_ready[1] !== 1'b1) begin
      tests_failed++; $display("FAIL l0_ready_after: got %b expected 1", src_ready[1]);
    end
    set_src(1, 1'b1, 5'd9, 32'd900);
    step();
    src_valid = '0;
    repeat (4) step();
    @(negedge clk);
    tests_run++;
    if (obs_label_q.size() != 1) begin
      tests_failed++; $display("FAIL l0_count: got %0d expected 1", obs_label_q.size());
    end else begin
      tests_run++;
      if (obs_label_q[0] !== 5'd9 || obs_data_q[0] !== 32'd900) begin
        tests_failed++;
        $display("FAIL l0_value: got label %0d data %0d expected label 9 data 900", obs_label_q[0], obs_data_q[0]);
      end
    end
  endtask

  task automatic test_flush();
    set_src(0, 1'b1, 5'd1, 32'd11);
    set_src(3, 1'b1, 5'd2, 32'd22);
    step();
    set_src(0, 1'b1, 5'd3, 32'd33);
    set_src(3, 1'b1, 5'd4, 32'd44);
    step();
    src_valid = '0;
    flush     = 1'b1;
    set_src(1, 1'b1, 5'd5, 32'd55);
    tests_run++;
    if (src_ready[1] !== 1'b1) begin
      tests_failed++; $display("FAIL flush_ready_src1: got %b expected 1", src_ready[1]);
    end
    step();
    flush     = 1'b0;
    src_valid = '0;
    clear_obs();
    @(negedge clk);
    tests_run++;
    if (BCEN !== 1'b0) begin
      tests_failed++; $display("FAIL flush_bcen: got %b expected 0", BCEN);
    end
    tests_run++;
    if (src_ready !== 4'b1111) begin
      tests_failed++; $display("FAIL flush_ready: got %b expected 1111", src_ready);
    end
    repeat (4) step();
    @(negedge clk);
    tests_run++;
    if (obs_label_q.size() != 0) begin
      tests_failed++; $display("FAIL flush_stale: got %0d broadcasts expected 0", obs_label_q.size());
    end
    set_src(2, 1'b1, 5'd7, 32'd700);
    step();
    src_valid = '0;
    repeat (4) step();
    @(negedge clk);
    tests_run++;
    if (obs_label_q.size() != 1) begin
      tests_failed++; $display("FAIL flush_after_count: got %0d expected 1", obs_label_q.size());
    end else begin
      tests_run++;
      if (obs_label_q[0] !== 5'd7 || obs_data_q[0] !== 32'd700) begin
        tests_failed++;
        $display("FAIL flush_after_value: got label %0d data %0d expected label 7 data 700", obs_label_q[0], obs_data_q[0]);
      end
    end
  endtask

  initial begin
    src_valid = '0;
    src_label = '0;
    src_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_label_zero();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
